// File: rtl/mac_feeder_if.sv
`default_nettype none
// ============================================================================
//  Module   : mac_feeder_if
//  Purpose  : Operand-load, control and MAC-side bus of mac_feeder.
//  Revision : 1.0 - initial release
// ============================================================================
interface mac_feeder_if #(
    parameter int BW      = 4,
    parameter int PSUM_BW = 16
);
    logic                in_valid;
    logic                in_ready;
    logic [BW-1:0]       in_a;
    logic [BW-1:0]       in_b;
    logic                start;
    logic [3:0]          len;
    logic                busy;
    logic [4*BW-1:0]     mac_a;
    logic [4*BW-1:0]     mac_b;
    logic [PSUM_BW-1:0]  mac_c;
    logic [PSUM_BW-1:0]  mac_out;
    logic [PSUM_BW-1:0]  result;
    logic                result_valid;

    // master: the environment around the feeder (loader, controller, MAC)
    modport master (
        output in_valid, in_a, in_b, start, len, mac_out,
        input  in_ready, busy, mac_a, mac_b, mac_c, result, result_valid
    );

    // slave: the feeder itself
    modport slave (
        input  in_valid, in_a, in_b, start, len, mac_out,
        output in_ready, busy, mac_a, mac_b, mac_c, result, result_valid
    );
endinterface
`default_nettype wire

// File: rtl/mac_feeder.sv
`default_nettype none
// ============================================================================
//  Module   : mac_feeder
//  Purpose  : Buffers act/weight pairs, issues 4-lane groups to mac_wrapper
//             and chains each group's psum into the next group.
//  Revision : 1.0 - initial release
// ============================================================================
module mac_feeder #(
    parameter int BW      = 4,
    parameter int PSUM_BW = 16,
    parameter int DEPTH   = 8,
    parameter int MAC_LAT = 2
) (
    input  wire logic      clk,
    input  wire logic      reset,
    mac_feeder_if.slave    bus
);
    localparam int c_ELEMS = 4 * DEPTH;
    localparam int c_IDX_W = (c_ELEMS > 1) ? $clog2(c_ELEMS) : 1;
    localparam int c_CNT_W = $clog2(c_ELEMS + 1);
    localparam int c_CYC_W = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_ISSUE = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;

    logic [BW-1:0]        r_buf_a [c_ELEMS];
    logic [BW-1:0]        r_buf_b [c_ELEMS];
    logic [c_CNT_W-1:0]   r_wr_cnt;
    logic [3:0]           r_grp;
    logic [3:0]           r_len;
    logic [c_CYC_W-1:0]   r_cyc;
    logic [4*BW-1:0]      r_mac_a;
    logic [4*BW-1:0]      r_mac_b;
    logic [PSUM_BW-1:0]   r_mac_c;
    logic [PSUM_BW-1:0]   r_result;
    logic                 r_result_valid;
    logic                 r_busy;

    logic                 w_in_ready;
    logic                 w_wr;
    logic                 w_start_ok;
    logic                 w_start_zero;
    logic                 w_cap;
    logic                 w_last;
    logic [3:0]           w_sel;
    logic [c_IDX_W-1:0]   w_idx;
    logic [4*BW-1:0]      w_pack_a;
    logic [4*BW-1:0]      w_pack_b;

    // The fill check uses wr_cnt before any write landing on the same edge.
    always_comb begin
        w_in_ready   = (r_state == S_IDLE) && (int'(r_wr_cnt) < c_ELEMS);
        w_wr         = bus.in_valid && w_in_ready;
        w_start_ok   = (r_state == S_IDLE) && bus.start && (bus.len != 4'd0) &&
                       (int'(bus.len) <= DEPTH) &&
                       (4 * int'(bus.len) <= int'(r_wr_cnt));
        w_start_zero = (r_state == S_IDLE) && bus.start && (bus.len == 4'd0);
        w_cap        = (r_state == S_ISSUE) && (r_cyc == c_CYC_W'(MAC_LAT - 1));
        w_last       = w_cap && (r_grp == r_len - 4'd1);
    end

    // Group 0 is packed on the start edge, group g+1 on every later capture.
    always_comb begin
        w_sel    = (r_state == S_IDLE) ? 4'd0 : r_grp + 4'd1;
        w_idx    = '0;
        w_pack_a = '0;
        w_pack_b = '0;
        for (int l = 0; l < 4; l++) begin
            w_idx = c_IDX_W'({w_sel, 2'b00}) + c_IDX_W'(l);
            w_pack_a[l*BW +: BW] = r_buf_a[w_idx];
            w_pack_b[l*BW +: BW] = r_buf_b[w_idx];
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_start_ok) w_state_nxt = S_ISSUE;
            S_ISSUE: if (w_last)     w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_buf_a[c_IDX_W'(r_wr_cnt)] <= bus.in_a;
            r_buf_b[c_IDX_W'(r_wr_cnt)] <= bus.in_b;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wr_cnt       <= '0;
            r_grp          <= '0;
            r_len          <= '0;
            r_cyc          <= '0;
            r_mac_a        <= '0;
            r_mac_b        <= '0;
            r_mac_c        <= '0;
            r_result       <= '0;
            r_result_valid <= 1'b0;
            r_busy         <= 1'b0;
        end else begin
            r_result_valid <= 1'b0;
            if (w_wr)
                r_wr_cnt <= r_wr_cnt + c_CNT_W'(1);
            if (w_start_zero) begin
                r_result       <= '0;
                r_result_valid <= 1'b1;
                r_wr_cnt       <= '0;
            end
            if (w_start_ok) begin
                r_mac_a <= w_pack_a;
                r_mac_b <= w_pack_b;
                r_mac_c <= '0;
                r_busy  <= 1'b1;
                r_grp   <= '0;
                r_cyc   <= '0;
                r_len   <= bus.len;
            end
            if (r_state == S_ISSUE) begin
                if (w_last) begin
                    r_result       <= bus.mac_out;
                    r_result_valid <= 1'b1;
                    r_busy         <= 1'b0;
                    r_wr_cnt       <= '0;
                end else if (w_cap) begin
                    r_mac_a <= w_pack_a;
                    r_mac_b <= w_pack_b;
                    r_mac_c <= bus.mac_out;
                    r_grp   <= r_grp + 4'd1;
                    r_cyc   <= '0;
                end else begin
                    r_cyc <= r_cyc + c_CYC_W'(1);
                end
            end
        end
    end

    assign bus.in_ready     = w_in_ready;
    assign bus.busy         = r_busy;
    assign bus.mac_a        = r_mac_a;
    assign bus.mac_b        = r_mac_b;
    assign bus.mac_c        = r_mac_c;
    assign bus.result       = r_result;
    assign bus.result_valid = r_result_valid;
endmodule
`default_nettype wire

// File: tb/tb_mac_feeder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mac_feeder
//  Purpose  : Directed and random bench for mac_feeder with a 2-edge MAC model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mac_feeder;
    localparam int BW      = 4;
    localparam int PSUM_BW = 16;
    localparam int DEPTH   = 8;
    localparam int LAT     = 2;

    typedef struct {
        logic [BW-1:0] a;
        logic [BW-1:0] b;
    } pair_t;

    logic  clk;
    logic  reset;
    int    checks   = 0;
    int    failures = 0;
    pair_t q[$];

    mac_feeder_if #(.BW(BW), .PSUM_BW(PSUM_BW)) bus ();

    mac_feeder #(.BW(BW), .PSUM_BW(PSUM_BW), .DEPTH(DEPTH), .MAC_LAT(LAT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // MAC model: one register stage, so mac_out is only valid LAT edges after the operands.
    function automatic logic [PSUM_BW-1:0] mac_fn(input logic [4*BW-1:0] a,
                                                  input logic [4*BW-1:0] b,
                                                  input logic [PSUM_BW-1:0] c);
        int s;
        int bv;
        s = int'(c);
        for (int l = 0; l < 4; l++) begin
            bv = $signed(b[l*BW +: BW]);
            s += int'(a[l*BW +: BW]) * bv;
        end
        return PSUM_BW'(s);
    endfunction

    always @(posedge clk) bus.mac_out <= mac_fn(bus.mac_a, bus.mac_b, bus.mac_c);

    // Reference: dot product of the first 4*g buffered pairs, wrapped to PSUM_BW.
    function automatic logic [PSUM_BW-1:0] grp_sum(input int g);
        int s;
        int bv;
        s = 0;
        for (int k = 0; k < 4 * g; k++) begin
            bv = $signed(q[k].b);
            s += int'(q[k].a) * bv;
        end
        return PSUM_BW'(s);
    endfunction

    function automatic logic [4*BW-1:0] pack(input int g, input bit use_b);
        logic [4*BW-1:0] r;
        r = '0;
        for (int l = 0; l < 4; l++)
            r[l*BW +: BW] = use_b ? q[4*g + l].b : q[4*g + l].a;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [BW-1:0] a, input logic [BW-1:0] b);
        bit exp_rdy;
        pair_t p;
        exp_rdy = (q.size() < 4 * DEPTH);
        chk("load_in_ready", bus.in_ready, exp_rdy);
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        tick();
        bus.in_valid = 1'b0;
        if (exp_rdy) begin
            p.a = a;
            p.b = b;
            q.push_back(p);
        end
    endtask

    task automatic load_rand(input int n);
        for (int i = 0; i < n; i++) load(BW'($urandom), BW'($urandom));
    endtask

    // Accepted start of n groups; optionally pokes start/in_valid during ISSUE.
    task automatic run(input int n, input bit inject);
        bus.start = 1'b1;
        bus.len   = 4'(n);
        tick();
        bus.start = 1'b0;
        bus.len   = 4'd0;
        chk("e0_busy", bus.busy, 1);
        chk("e0_mac_a", bus.mac_a, pack(0, 1'b0));
        chk("e0_mac_b", bus.mac_b, pack(0, 1'b1));
        chk("e0_mac_c", bus.mac_c, 0);
        chk("e0_in_ready", bus.in_ready, 0);
        for (int k = 1; k < LAT * n; k++) begin
            if (inject && k == 1) begin
                bus.start    = 1'b1;
                bus.len      = 4'd1;
                bus.in_valid = 1'b1;
                bus.in_a     = 4'hF;
                bus.in_b     = 4'h7;
            end
            tick();
            bus.start    = 1'b0;
            bus.in_valid = 1'b0;
            bus.len      = 4'd0;
            chk("issue_rv", bus.result_valid, 0);
            chk("issue_busy", bus.busy, 1);
            if (inject && k == 1) chk("issue_in_ready", bus.in_ready, 0);
            if (k % LAT == 0) begin
                chk("grp_mac_a", bus.mac_a, pack(k / LAT, 1'b0));
                chk("grp_mac_b", bus.mac_b, pack(k / LAT, 1'b1));
                chk("grp_mac_c", bus.mac_c, grp_sum(k / LAT));
            end
        end
        tick();
        chk("res_valid", bus.result_valid, 1);
        chk("res_value", bus.result, grp_sum(n));
        chk("res_busy", bus.busy, 0);
        q.delete();
        tick();
        chk("post_rv", bus.result_valid, 0);
        chk("post_in_ready", bus.in_ready, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_a     = '0;
        bus.in_b     = '0;
        bus.start    = 1'b0;
        bus.len      = '0;
        tick();
        tick();
        chk("rst_busy", bus.busy, 0);
        chk("rst_rv", bus.result_valid, 0);
        chk("rst_mac_a", bus.mac_a, 0);
        chk("rst_mac_b", bus.mac_b, 0);
        chk("rst_mac_c", bus.mac_c, 0);
        chk("rst_result", bus.result, 0);
        reset = 1'b1;
        tick();
        chk("rel_in_ready", bus.in_ready, 1);

        // 20 pairs of 3 x -2 over 5 groups
        for (int i = 0; i < 20; i++) load(4'd3, 4'hE);
        run(5, 1'b0);
        chk("t2_result", bus.result, 16'hFF88);

        // full buffer, 33rd pair dropped
        for (int i = 0; i < 32; i++) load(4'd15, 4'h8);
        chk("full_in_ready", bus.in_ready, 0);
        load(4'd1, 4'd1);
        run(8, 1'b0);
        chk("t3_result", bus.result, 16'hF100);

        // too few elements: start ignored, then completed
        for (int i = 0; i < 8; i++) load(4'd1, 4'd7);
        bus.start = 1'b1;
        bus.len   = 4'd3;
        tick();
        bus.start = 1'b0;
        chk("short_busy", bus.busy, 0);
        chk("short_rv", bus.result_valid, 0);
        chk("short_in_ready", bus.in_ready, 1);
        for (int i = 0; i < 4; i++) load(4'd1, 4'd7);
        run(3, 1'b0);
        chk("t4_result", bus.result, 16'h0054);

        // zero-length start consumes the buffer
        load_rand(3);
        bus.start = 1'b1;
        bus.len   = 4'd0;
        tick();
        bus.start = 1'b0;
        chk("zero_rv", bus.result_valid, 1);
        chk("zero_result", bus.result, 0);
        chk("zero_busy", bus.busy, 0);
        q.delete();
        tick();
        chk("zero_rv_end", bus.result_valid, 0);

        // start and in_valid during ISSUE are ignored
        load_rand(8);
        run(2, 1'b1);

        // reset mid-ISSUE
        load_rand(8);
        bus.start = 1'b1;
        bus.len   = 4'd2;
        tick();
        bus.start = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        chk("mid_rst_busy", bus.busy, 0);
        chk("mid_rst_rv", bus.result_valid, 0);
        chk("mid_rst_in_ready", bus.in_ready, 1);
        chk("mid_rst_mac_a", bus.mac_a, 0);
        chk("mid_rst_mac_c", bus.mac_c, 0);
        chk("mid_rst_result", bus.result, 0);
        reset = 1'b1;
        q.delete();
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("after_rst_rv", bus.result_valid, 0);
        end

        // start together with the write that would complete the count
        load_rand(7);
        bus.start    = 1'b1;
        bus.len      = 4'd2;
        bus.in_valid = 1'b1;
        bus.in_a     = 4'd9;
        bus.in_b     = 4'hB;
        tick();
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        q.push_back('{a: 4'd9, b: 4'hB});
        chk("same_cyc_busy", bus.busy, 0);
        run(2, 1'b0);

        // random lengths with random surplus elements
        for (int r = 0; r < 6; r++) begin
            int n;
            n = $urandom_range(1, DEPTH);
            load_rand(4 * n + $urandom_range(0, 4 * (DEPTH - n)));
            run(n, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
